// File: rtl/ppu_line_buffer.sv
// Ping-pong scanline buffer with palette lookup.
// The renderer fills the write bank with 5-bit palette addresses while the
// VGA side reads the other bank through a two-stage read/palette pipeline.
module ppu_line_buffer #(
  parameter int NUM_PIXELS = 256
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_valid,
  input  logic [4:0] wr_pixel,
  output logic       wr_ready,
  input  logic       line_swap,
  input  logic       rd_en,
  input  logic [7:0] rd_x,
  output logic [5:0] color_out,
  output logic       color_valid,
  output logic       underrun,
  output logic       overrun,
  input  logic       pal_we,
  input  logic [4:0] pal_addr,
  input  logic [5:0] pal_data
);

  localparam int AW = $clog2(NUM_PIXELS);

  typedef enum logic {
    FILLING = 1'b0,
    FULL    = 1'b1
  } wr_state_t;

  wr_state_t         state_q, state_d;
  logic              wr_bank_q, wr_bank_d;
  logic [AW-1:0]     wr_count_q, wr_count_d;
  logic              underrun_d, overrun_d;
  logic              wr_fire;

  // Both line banks share one array; the bank select is the address MSB.
  logic [4:0]        line_mem [0:2*NUM_PIXELS-1];
  logic [5:0]        pal_mem  [0:31];

  logic [4:0]        pix_p1;
  logic              vld_p1;

  // Transparent pixels (low two bits zero) all resolve to the universal
  // background entry, regardless of the sprite/background bit.
  function automatic logic [4:0] pal_index(input logic [4:0] pix);
    if (pix[1:0] == 2'b00) return 5'h00;
    return pix;
  endfunction

  // Sprite entries 10/14/18/1C alias onto background entries 00/04/08/0C.
  function automatic logic [4:0] pal_mirror(input logic [4:0] addr);
    if (addr[4] && (addr[1:0] == 2'b00)) return {1'b0, addr[3:0]};
    return addr;
  endfunction

  // Write-side next state: fill until the last column, then hold until a swap.
  always_comb begin
    state_d    = state_q;
    wr_bank_d  = wr_bank_q;
    wr_count_d = wr_count_q;
    underrun_d = 1'b0;
    overrun_d  = 1'b0;
    wr_fire    = 1'b0;
    wr_ready   = (state_q == FILLING);
    case (state_q)
      FILLING: begin
        wr_fire = wr_valid;
        if (wr_valid) begin
          wr_count_d = wr_count_q + AW'(1);
          if (wr_count_q == AW'(NUM_PIXELS - 1)) state_d = FULL;
        end
        // A swap on a partial line is refused; the old read line repeats.
        if (line_swap) underrun_d = 1'b1;
      end
      FULL: begin
        overrun_d = wr_valid;
        if (line_swap) begin
          state_d    = FILLING;
          wr_bank_d  = ~wr_bank_q;
          wr_count_d = '0;
        end
      end
      default: state_d = FILLING;
    endcase
  end

  // Write-side control registers and the error pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= FILLING;
      wr_bank_q  <= 1'b0;
      wr_count_q <= '0;
      underrun   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_bank_q  <= wr_bank_d;
      wr_count_q <= wr_count_d;
      underrun   <= underrun_d;
      overrun    <= overrun_d;
    end
  end

  // Line storage write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_fire) line_mem[{wr_bank_q, wr_count_q}] <= wr_pixel;
  end

  // Palette write port with sprite-to-background aliasing.
  always_ff @(posedge clk) begin
    if (pal_we) pal_mem[pal_mirror(pal_addr)] <= pal_data;
  end

  // ---- stage 1: fetch the palette address from the read bank ----
  // Uses the registered bank select, so a swap only affects later requests.
  always_ff @(posedge clk) begin
    pix_p1 <= line_mem[{~wr_bank_q, rd_x[AW-1:0]}];
  end

  // Stage-1 valid flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) vld_p1 <= 1'b0;
    else          vld_p1 <= rd_en;
  end

  // ---- stage 2: palette lookup, output holds when no request ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      color_out   <= 6'h00;
      color_valid <= 1'b0;
    end else begin
      color_valid <= vld_p1;
      if (vld_p1) color_out <= pal_mem[pal_index(pix_p1)];
    end
  end

endmodule

// File: tb/tb_ppu_line_buffer.sv
// Directed bench for ppu_line_buffer: reads push expected colours into a
// queue, and an independent monitor pops and compares on color_valid.
module tb_ppu_line_buffer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic [4:0] wr_pixel = 5'h00;
  logic       wr_ready;
  logic       line_swap = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] rd_x = 8'h00;
  logic [5:0] color_out;
  logic       color_valid;
  logic       underrun;
  logic       overrun;
  logic       pal_we = 1'b0;
  logic [4:0] pal_addr = 5'h00;
  logic [5:0] pal_data = 6'h00;

  typedef struct {
    logic [5:0] color;
    int         due;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  ppu_line_buffer #(.NUM_PIXELS(256)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_valid(wr_valid), .wr_pixel(wr_pixel), .wr_ready(wr_ready),
    .line_swap(line_swap), .rd_en(rd_en), .rd_x(rd_x),
    .color_out(color_out), .color_valid(color_valid),
    .underrun(underrun), .overrun(overrun),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout want completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every presented colour must match the oldest pending request.
  always @(negedge clk) begin
    if (reset_n && color_valid) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL spurious_valid: got color %0h with no request (cyc %0d)", color_out, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (color_out !== e.color || cyc != e.due) begin
          n_fail++;
          $display("FAIL color: got %0h at cyc %0d want %0h at cyc %0d", color_out, cyc, e.color, e.due);
        end
      end
    end
  end

  task automatic cycle();
    @(negedge clk);
  endtask

  task automatic pal_wr(input logic [4:0] a, input logic [5:0] d);
    pal_we = 1'b1; pal_addr = a; pal_data = d;
    cycle();
    pal_we = 1'b0;
  endtask

  task automatic wr_px(input logic [4:0] p);
    wr_valid = 1'b1; wr_pixel = p;
    cycle();
    wr_valid = 1'b0;
  endtask

  task automatic swap();
    line_swap = 1'b1;
    cycle();
    line_swap = 1'b0;
  endtask

  task automatic rd(input logic [7:0] x, input logic [5:0] exp);
    exp_t e;
    e.color = exp; e.due = cyc + 2;
    q.push_back(e);
    rd_en = 1'b1; rd_x = x;
    cycle();
    rd_en = 1'b0;
  endtask

  initial begin
    int bad;
    // Reset state
    repeat (2) cycle();
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_color_valid", color_valid, 0);
    chk("rst_color_out", color_out, 6'h00);
    chk("rst_underrun", underrun, 0);
    chk("rst_overrun", overrun, 0);
    reset_n = 1'b1;
    cycle();

    // Palette write and background rule
    pal_wr(5'h00, 6'h0F);
    pal_wr(5'h05, 6'h16);
    for (int i = 0; i < 256; i++) wr_px((i == 3) ? 5'h05 : 5'h04);
    chk("full_after_256", wr_ready, 0);
    swap();
    chk("ready_after_swap", wr_ready, 1);
    chk("no_underrun_on_good_swap", underrun, 0);
    rd(8'd3, 6'h16);
    rd(8'd4, 6'h0F);
    repeat (3) cycle();

    // Mirroring: 5'h10 lands in entry 0
    pal_wr(5'h10, 6'h2A);
    pal_wr(5'h01, 6'h21);
    pal_wr(5'h02, 6'h12);
    pal_wr(5'h03, 6'h05);
    rd(8'd4, 6'h2A);
    rd(8'd3, 6'h16);
    repeat (3) cycle();

    // Ping-pong: fill A, swap, fill B while reading A, swap, read B
    for (int i = 0; i < 256; i++) wr_px(5'h01);
    swap();
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      exp_t e;
      if (!wr_ready) bad++;
      e.color = 6'h21; e.due = cyc + 2;
      q.push_back(e);
      wr_valid = 1'b1; wr_pixel = 5'h02;
      rd_en = 1'b1; rd_x = 8'(i);
      cycle();
    end
    wr_valid = 1'b0; rd_en = 1'b0;
    chk("ready_during_fill_B", bad, 0);
    chk("full_after_B", wr_ready, 0);
    swap();
    rd(8'd0, 6'h12);
    rd(8'd255, 6'h12);
    repeat (3) cycle();

    // Backpressure and overrun
    for (int i = 0; i < 256; i++) wr_px(5'h03);
    chk("full_before_257", wr_ready, 0);
    chk("no_overrun_yet", overrun, 0);
    wr_px(5'h01);
    chk("overrun_pulse", overrun, 1);
    cycle();
    chk("overrun_single", overrun, 0);
    swap();
    rd(8'd0, 6'h05);
    rd(8'd100, 6'h05);
    repeat (3) cycle();

    // Underrun after 100 writes, then simultaneous swap with the 256th write
    for (int i = 0; i < 100; i++) wr_px(5'h01);
    swap();
    chk("underrun_pulse", underrun, 1);
    chk("ready_after_underrun", wr_ready, 1);
    rd(8'd0, 6'h05);
    chk("underrun_single", underrun, 0);
    for (int i = 0; i < 155; i++) wr_px(5'h01);
    wr_valid = 1'b1; wr_pixel = 5'h02; line_swap = 1'b1;
    cycle();
    wr_valid = 1'b0; line_swap = 1'b0;
    chk("underrun_simul", underrun, 1);
    chk("full_after_simul", wr_ready, 0);
    rd(8'd0, 6'h05);
    swap();
    chk("no_underrun_next_swap", underrun, 0);
    chk("ready_after_next_swap", wr_ready, 1);
    rd(8'd150, 6'h21);
    rd(8'd255, 6'h12);
    rd(8'd0, 6'h21);
    repeat (3) cycle();

    // Async reset mid-line with a read in flight
    for (int i = 0; i < 50; i++) wr_px(5'h02);
    rd_en = 1'b1; rd_x = 8'd0;
    @(posedge clk);
    #2;
    rd_en = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midrst_wr_ready", wr_ready, 1);
    chk("midrst_color_valid", color_valid, 0);
    chk("midrst_color_out", color_out, 6'h00);
    cycle();
    reset_n = 1'b1;
    cycle();
    chk("postrst_color_valid", color_valid, 0);
    for (int i = 0; i < 256; i++) wr_px(5'h05);
    chk("postrst_full", wr_ready, 0);
    swap();
    chk("postrst_ready", wr_ready, 1);
    rd(8'd10, 6'h16);
    rd(8'd3, 6'h16);
    repeat (4) cycle();

    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
